// File: rtl/beacon_counter.sv
// Multi-channel beacon generator: per-channel periodic counters feeding a round-robin UART byte register.
// Optional sticky overrun flags are built only when BEACON_COUNTER_OVERRUN_EN is defined.
module beacon_counter #(
    parameter int          N_CH           = 4,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h3b9aca00,
    parameter logic [7:0]  DEFAULT_CHAR   = 8'h50,
    localparam int         CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             r_reset,
    input  logic             i_enable,
    input  logic             i_cfg_we,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  logic [CNT_W-1:0] i_cfg_period,
    input  logic [7:0]       i_cfg_char,
    input  logic             i_uart_ready,
    output logic             o_uart_valid,
    output logic [7:0]       o_uart_data,
    output logic [CH_W-1:0]  o_uart_ch,
    output logic [N_CH-1:0]  o_tick,
    output logic [N_CH-1:0]  o_overrun,
    input  logic [N_CH-1:0]  i_ovr_clr
);

    logic [CNT_W-1:0] cnt    [N_CH];
    logic [CNT_W-1:0] period [N_CH];
    logic [7:0]       chr    [N_CH];

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] cfg_hit;
    logic [N_CH-1:0] wrap;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] rr_next;
    logic            sel_vld;
    logic            load;
    int              idx;

    // A config write to a channel suppresses that channel's wrap in the same cycle.
    always_comb begin
        cfg_hit = '0;
        wrap    = '0;
        for (int i = 0; i < N_CH; i++) begin
            cfg_hit[i] = i_cfg_we && (int'(i_cfg_ch) == i);
            wrap[i]    = i_enable && (period[i] != '0) && (cnt[i] == period[i] - CNT_W'(1))
                         && !cfg_hit[i];
        end
    end

    // Round-robin search starting at rr_ptr, wrapping modulo N_CH.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!sel_vld && pending[CH_W'(idx)]) begin
                sel_vld = 1'b1;
                sel     = CH_W'(idx);
            end
        end
    end

    assign load    = (!o_uart_valid || i_uart_ready) && sel_vld;
    assign rr_next = (int'(sel) == N_CH - 1) ? '0 : sel + CH_W'(1);

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant[i] = load && (int'(sel) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            rr_ptr       <= '0;
            o_uart_valid <= 1'b0;
            o_uart_data  <= 8'h00;
            o_uart_ch    <= '0;
            o_tick       <= '0;
            pending      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i]    <= '0;
                period[i] <= CNT_W'(DEFAULT_PERIOD);
                chr[i]    <= DEFAULT_CHAR;
            end
        end else begin
            o_tick  <= wrap;
            // A wrap on the granted channel keeps its pending bit set.
            pending <= (pending & ~grant & ~cfg_hit) | wrap;
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_hit[i]) begin
                    cnt[i]    <= '0;
                    period[i] <= i_cfg_period;
                    chr[i]    <= i_cfg_char;
                end else if (i_enable) begin
                    cnt[i] <= ((period[i] == '0) || wrap[i]) ? '0 : cnt[i] + CNT_W'(1);
                end
            end
            if (load) begin
                o_uart_valid <= 1'b1;
                o_uart_data  <= chr[sel];
                o_uart_ch    <= sel;
                rr_ptr       <= rr_next;
            end else if (i_uart_ready) begin
                o_uart_valid <= 1'b0;
            end
        end
    end

`ifdef BEACON_COUNTER_OVERRUN_EN
    logic [N_CH-1:0] ovr_q;
    logic [N_CH-1:0] ovr_set;

    assign ovr_set = wrap & pending & ~grant;

    always_ff @(posedge clk) begin
        if (r_reset) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= (ovr_q & ~i_ovr_clr) | ovr_set;
        end
    end

    assign o_overrun = ovr_q;
`else
    logic unused_ovr_clr;

    assign unused_ovr_clr = ^i_ovr_clr;
    assign o_overrun      = '0;
`endif

endmodule

// File: tb/tb_beacon_counter.sv
// Randomized and directed bench for beacon_counter against a cycle-level behavioural model.
module tb_beacon_counter;

    logic       clk = 1'b0;
    logic       r_reset = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_cfg_we = 1'b0;
    logic [1:0] i_cfg_ch = 2'd0;
    logic [7:0] i_cfg_period = 8'd0;
    logic [7:0] i_cfg_char = 8'd0;
    logic       i_uart_ready = 1'b0;
    logic       o_uart_valid;
    logic [7:0] o_uart_data;
    logic [1:0] o_uart_ch;
    logic [3:0] o_tick;
    logic [3:0] o_overrun;
    logic [3:0] i_ovr_clr = 4'd0;

    int checks = 0;
    int failures = 0;

    int         m_cnt [4];
    int         m_per [4];
    logic [7:0] m_chr [4];
    bit         m_pend [4];
    int         m_rr;
    logic       m_vld;
    logic [7:0] m_dat;
    logic [1:0] m_ch;
    logic [3:0] m_tick;
    logic [3:0] m_ovr;

    beacon_counter #(
        .N_CH(4), .CNT_W(8), .DEFAULT_PERIOD(32'd10), .DEFAULT_CHAR(8'h50)
    ) dut (
        .clk(clk), .r_reset(r_reset), .i_enable(i_enable), .i_cfg_we(i_cfg_we),
        .i_cfg_ch(i_cfg_ch), .i_cfg_period(i_cfg_period), .i_cfg_char(i_cfg_char),
        .i_uart_ready(i_uart_ready), .o_uart_valid(o_uart_valid), .o_uart_data(o_uart_data),
        .o_uart_ch(o_uart_ch), .o_tick(o_tick), .o_overrun(o_overrun), .i_ovr_clr(i_ovr_clr)
    );

    always #5 clk = ~clk;

    // Model of what the design should show after the coming edge, given current inputs.
    task automatic model_step();
        int g;
        bit w;
        bit hit;
        logic [3:0] ovr_set;
        if (r_reset) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0; m_per[i] = 10; m_chr[i] = 8'h50; m_pend[i] = 0;
            end
            m_rr = 0; m_vld = 0; m_dat = 8'h00; m_ch = 2'd0; m_tick = 4'h0; m_ovr = 4'h0;
            return;
        end
        g = -1;
        if (!m_vld || i_uart_ready) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
            end
        end
        if (g >= 0) begin
            m_vld = 1; m_dat = m_chr[g]; m_ch = 2'(g); m_rr = (g + 1) % 4;
        end else if (i_uart_ready) begin
            m_vld = 0;
        end
        ovr_set = 4'h0;
        for (int i = 0; i < 4; i++) begin
            hit = i_cfg_we && (int'(i_cfg_ch) == i);
            w = i_enable && m_per[i] != 0 && m_cnt[i] == m_per[i] - 1 && !hit;
            m_tick[i] = w;
            ovr_set[i] = w && m_pend[i] && (g != i);
            if (hit) m_pend[i] = 0;
            else if (w) m_pend[i] = 1;
            else if (g == i) m_pend[i] = 0;
            if (hit) begin
                m_cnt[i] = 0; m_per[i] = int'(i_cfg_period); m_chr[i] = i_cfg_char;
            end else if (i_enable) begin
                m_cnt[i] = (m_per[i] == 0 || w) ? 0 : (m_cnt[i] + 1) % 256;
            end
        end
`ifdef BEACON_COUNTER_OVERRUN_EN
        m_ovr = (m_ovr & ~i_ovr_clr) | ovr_set;
`else
        m_ovr = 4'h0;
`endif
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r_reset = 1; i_enable = 1; i_cfg_we = 0; i_uart_ready = 1; i_ovr_clr = 4'h0;
        adv();
        r_reset = 0;
    endtask

    task automatic test_reset();
        r_reset = 1; i_enable = 1; i_uart_ready = 0;
        adv(); adv();
        checks++;
        if ({o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch} !== 23'd0) begin
            failures++;
            $display("FAIL reset_state got={tick,ovr,v,d,ch}=%h exp=0",
                     {o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch});
        end
        r_reset = 0;
    endtask

    task automatic test_default_ticks();
        int first_tick = -1;
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            adv();
            checks++;
            if ({o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch} !== {m_tick, m_ovr, m_vld, m_dat, m_ch}) begin
                failures++;
                $display("FAIL default_model n=%0d got=%h exp=%h", n,
                         {o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch}, {m_tick, m_ovr, m_vld, m_dat, m_ch});
            end
            if (o_tick == 4'hF && first_tick < 0) first_tick = n;
            if (n >= 11 && n <= 14) begin
                checks++;
                if ({o_uart_valid, o_uart_data, o_uart_ch} !== {1'b1, 8'h50, 2'(n - 11)}) begin
                    failures++;
                    $display("FAIL default_bytes n=%0d got v=%b d=%h ch=%0d exp v=1 d=50 ch=%0d",
                             n, o_uart_valid, o_uart_data, o_uart_ch, n - 11);
                end
            end
        end
        checks++;
        if (first_tick != 10) begin
            failures++;
            $display("FAIL default_first_tick got=%0d exp=10", first_tick);
        end
    endtask

    task automatic test_cfg_write();
        i_uart_ready = 1;
        for (int n = 0; n < 4; n++) adv();
        i_cfg_we = 1; i_cfg_ch = 2'd2; i_cfg_period = 8'd3; i_cfg_char = 8'h41;
        adv();
        i_cfg_we = 0;
        for (int n = 1; n <= 12; n++) begin
            adv();
            checks++;
            if ({o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch} !== {m_tick, m_ovr, m_vld, m_dat, m_ch}) begin
                failures++;
                $display("FAIL cfg_model n=%0d got=%h exp=%h", n,
                         {o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch}, {m_tick, m_ovr, m_vld, m_dat, m_ch});
            end
            checks++;
            if (o_tick[2] !== (n % 3 == 0)) begin
                failures++;
                $display("FAIL cfg_tick2 n=%0d got=%b exp=%b", n, o_tick[2], (n % 3 == 0));
            end
            if (o_uart_valid && o_uart_ch == 2'd2) begin
                checks++;
                if (o_uart_data !== 8'h41) begin
                    failures++;
                    $display("FAIL cfg_byte n=%0d got=%h exp=41", n, o_uart_data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_uart_ready = 0;
        for (int n = 1; n <= 34; n++) begin
            adv();
            checks++;
            if ({o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch} !== {m_tick, m_ovr, m_vld, m_dat, m_ch}) begin
                failures++;
                $display("FAIL bp_model n=%0d got=%h exp=%h", n,
                         {o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch}, {m_tick, m_ovr, m_vld, m_dat, m_ch});
            end
            if (n >= 11) begin
                checks++;
                if ({o_uart_valid, o_uart_data, o_uart_ch} !== {1'b1, 8'h50, 2'd0}) begin
                    failures++;
                    $display("FAIL bp_hold n=%0d got v=%b d=%h ch=%0d exp v=1 d=50 ch=0",
                             n, o_uart_valid, o_uart_data, o_uart_ch);
                end
            end
        end
        checks++;
`ifdef BEACON_COUNTER_OVERRUN_EN
        if (o_overrun !== 4'hF) begin
            failures++;
            $display("FAIL bp_overrun got=%h exp=F", o_overrun);
        end
`else
        if (o_overrun !== 4'h0) begin
            failures++;
            $display("FAIL bp_overrun got=%h exp=0", o_overrun);
        end
`endif
        i_uart_ready = 1; i_ovr_clr = 4'hF;
        adv();
        i_ovr_clr = 4'h0;
        checks++;
        if (o_overrun !== 4'h0) begin
            failures++;
            $display("FAIL ovr_clear got=%h exp=0", o_overrun);
        end
        for (int n = 1; n <= 8; n++) begin
            adv();
            checks++;
            if ({o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch} !== {m_tick, m_ovr, m_vld, m_dat, m_ch}) begin
                failures++;
                $display("FAIL bp_drain n=%0d got=%h exp=%h", n,
                         {o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch}, {m_tick, m_ovr, m_vld, m_dat, m_ch});
            end
        end
    endtask

    task automatic test_period_edges();
        int gap = 0;
        i_uart_ready = 1;
        i_cfg_we = 1; i_cfg_ch = 2'd1; i_cfg_period = 8'd0; i_cfg_char = 8'h31;
        adv();
        i_cfg_ch = 2'd3; i_cfg_period = 8'd1; i_cfg_char = 8'h33;
        adv();
        i_cfg_we = 0;
        for (int n = 1; n <= 40; n++) begin
            adv();
            checks++;
            if ({o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch} !== {m_tick, m_ovr, m_vld, m_dat, m_ch}) begin
                failures++;
                $display("FAIL edge_model n=%0d got=%h exp=%h", n,
                         {o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch}, {m_tick, m_ovr, m_vld, m_dat, m_ch});
            end
            checks++;
            if (o_tick[1] !== 1'b0 || o_tick[3] !== 1'b1) begin
                failures++;
                $display("FAIL edge_ticks n=%0d got t1=%b t3=%b exp t1=0 t3=1", n, o_tick[1], o_tick[3]);
            end
            gap = (o_uart_valid && o_uart_ch == 2'd3) ? 0 : gap + 1;
            if (n >= 6) begin
                checks++;
                if (gap > 3) begin
                    failures++;
                    $display("FAIL edge_rr n=%0d got gap=%0d exp<=3", n, gap);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int waited = 0;
        i_uart_ready = 0;
        while (!o_uart_valid && waited < 20) begin
            adv();
            waited++;
        end
        checks++;
        if (!o_uart_valid) begin
            failures++;
            $display("FAIL midflight_wait got valid=0 exp valid=1 within 20 cycles");
        end
        r_reset = 1; i_enable = 1; i_uart_ready = 1;
        i_cfg_we = 1; i_cfg_ch = 2'd0; i_cfg_period = 8'd5; i_cfg_char = 8'h77;
        adv();
        r_reset = 0; i_cfg_we = 0; i_uart_ready = 0;
        checks++;
        if ({o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch} !== 23'd0) begin
            failures++;
            $display("FAIL midflight_reset got=%h exp=0",
                     {o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch});
        end
        i_uart_ready = 1;
        for (int n = 1; n <= 12; n++) begin
            adv();
            checks++;
            if (o_tick !== ((n == 10) ? 4'hF : 4'h0)) begin
                failures++;
                $display("FAIL midflight_period n=%0d got tick=%h exp=%h", n, o_tick, (n == 10) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 1; n <= 600; n++) begin
            r_reset      = ($urandom_range(0, 199) == 0);
            i_enable     = ($urandom_range(0, 7) != 0);
            i_cfg_we     = ($urandom_range(0, 7) == 0);
            i_cfg_ch     = 2'($urandom_range(0, 3));
            i_cfg_period = 8'($urandom_range(0, 6));
            i_cfg_char   = 8'($urandom);
            i_uart_ready = ($urandom_range(0, 2) != 0);
            i_ovr_clr    = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            adv();
            checks++;
            if ({o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch} !== {m_tick, m_ovr, m_vld, m_dat, m_ch}) begin
                failures++;
                $display("FAIL random_model n=%0d got=%h exp=%h", n,
                         {o_tick, o_overrun, o_uart_valid, o_uart_data, o_uart_ch}, {m_tick, m_ovr, m_vld, m_dat, m_ch});
            end
        end
        r_reset = 0; i_cfg_we = 0; i_ovr_clr = 4'h0;
    endtask

    initial begin
        test_reset();
        test_default_ticks();
        test_cfg_write();
        test_backpressure();
        test_period_edges();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
